// File: rtl/regfile_mem_rtl_if.sv
// regfile_mem_rtl_if: request/response channels of the register-file memory.
interface regfile_mem_rtl_if #(
  parameter int p_nwords = 8,
  parameter int p_nbits  = 32
);
  logic                        req_val;
  logic                        req_rdy;
  logic                        req_type;
  logic [$clog2(p_nwords)-1:0] req_addr;
  logic [p_nbits-1:0]          req_data;
  logic                        resp_val;
  logic                        resp_rdy;
  logic                        resp_type;
  logic [p_nbits-1:0]          resp_data;
  modport master (
    output req_val, req_type, req_addr, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_data
  );
  modport slave (
    input  req_val, req_type, req_addr, req_data, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_data
  );
endinterface

// File: rtl/regfile_mem_rtl.sv
// regfile_mem_rtl: word-addressed register memory with in-order 2-entry response queue.
module Decoder_RTL #(
  parameter int p_nbits = 8
) (
  input  logic [$clog2(p_nbits)-1:0] sel,
  output logic [p_nbits-1:0]         onehot
);
  assign onehot = p_nbits'(1) << sel;
endmodule

module regfile_mem_rtl #(
  parameter int p_nwords = 8,
  parameter int p_nbits  = 32
) (
  input logic              clk,
  input logic              reset,
  regfile_mem_rtl_if.slave bus
);
  logic [p_nbits-1:0]  mem [p_nwords];
  logic [p_nwords-1:0] wen;
  logic                q_type [2];
  logic [p_nbits-1:0]  q_data [2];
  logic                head, tail;
  logic [1:0]          count;
  logic                req_go, resp_go;
  Decoder_RTL #(.p_nbits(p_nwords)) dec (.sel(bus.req_addr), .onehot(wen));
  // Ready depends only on queue occupancy, never on resp_rdy.
  assign bus.req_rdy   = count != 2'd2;
  assign bus.resp_val  = count != 2'd0;
  assign bus.resp_type = q_type[head];
  assign bus.resp_data = q_data[head];
  assign req_go        = bus.req_val & bus.req_rdy;
  assign resp_go       = bus.resp_val & bus.resp_rdy;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_nwords; i++) mem[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        q_type[i] <= 1'b0;
        q_data[i] <= '0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      for (int i = 0; i < p_nwords; i++)
        if (req_go && bus.req_type && wen[i]) mem[i] <= bus.req_data;
      if (req_go) begin
        q_type[tail] <= bus.req_type;
        q_data[tail] <= bus.req_type ? '0 : mem[bus.req_addr];
        tail         <= ~tail;
      end
      if (resp_go) head <= ~head;
      count <= count + 2'(req_go) - 2'(resp_go);
    end
  end
endmodule

// File: doc/regfile_mem_rtl.md
# regfile_mem_rtl

Small word-addressed memory with a latency-insensitive request/response interface, built from a register array whose one-hot word write-enables come from the team's `Decoder_RTL` block (instantiated with `p_nbits = p_nwords`). It sits directly downstream of the decoder and consumes its one-hot output as the per-word write-enable bus. It serves as the test memory for processor and cache sections. Responses return in order through an internal 2-entry response queue, so `req_rdy` never depends combinationally on `resp_rdy`.

## Interface
- `p_nwords`, default 8: number of words; power of two, ≥ 2.
- `p_nbits`, default 32: word width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous and active-low (`reset == 0` resets immediately).
- `req_val`  in  1  request valid.
- `req_rdy`  out  1  request ready.
- `req_type`  in  1  0 = read, 1 = write.
- `req_addr`  in  $clog2(p_nwords)  word address.
- `req_data`  in  p_nbits  write data; ignored for reads.
- `resp_val`  out  1  response valid.
- `resp_rdy`  in  1  response ready.
- `resp_type`  out  1  echoes the request type.
- `resp_data`  out  p_nbits  read data; 0 for writes.

## Operation
- Transfer on a channel occurs in any cycle with `val && rdy` sampled at the rising edge. `req_go = req_val & req_rdy`; `resp_go = resp_val & resp_rdy`.
- Storage is `p_nwords` registers. `Decoder_RTL` maps `req_addr` to a one-hot vector. Word *i* is written with `req_data` when `req_go & req_type & onehot[i]`.
- A read captures `mem[req_addr]` as held before the accepting edge. Because only one request is accepted per cycle, no same-cycle read/write conflict exists.
- Response queue has 2 entries in FIFO order, with head/tail pointers and a 2-bit `count` (0..2).
  - On `req_go`, the entry {type, data} is enqueued at the accepting edge.
  - On `resp_go`, the head is dequeued.
  - Simultaneous enqueue and dequeue leaves `count` unchanged and advances both pointers.
- `req_rdy = (count != 2)`, derived from registered state only.
- `resp_val = (count != 0)`; `resp_type`/`resp_data` drive the head entry.
- Pointers wrap modulo 2.
- Enqueue with `count == 2` cannot occur because `req_rdy == 0`. Dequeue with `count == 0` cannot occur because `resp_val == 0`.
- Reset (asserted at any time, including mid-transaction):
  - All memory words, pointers and `count` clear to 0.
  - Queued responses are discarded.
  - Outputs go to: `req_rdy = 1`, `resp_val = 0`, `resp_type = 0`, `resp_data = 0`.
  - No transfer is accepted while `reset == 0`.

## Timing
- Latency is 1 cycle minimum: a request accepted at edge *t* produces `resp_val = 1` in the cycle after *t*. There is no bypass path to a same-cycle response.
- Throughput is one request per cycle sustained while `resp_rdy = 1`, with steady-state `count` of 1.
- Under backpressure (`resp_rdy = 0`):
  - Two requests are accepted, then `req_rdy` falls.
  - `req_rdy` rises in the cycle after the first `resp_go`.
- Read-after-write to the same address on consecutive accepted requests returns the newly written value.
- Response outputs are stable while `resp_val & !resp_rdy`.

## Test plan
- **Reset values:** drive `reset = 0` for 2 cycles, release → `req_rdy = 1`, `resp_val = 0`; read addr 5 → `resp_data = 0`, `resp_type = 0`.
- **Write then read:** write addr 3 with 0xDEADBEEF → next cycle `resp_val = 1`, `resp_type = 1`, `resp_data = 0`. Then read addr 3 → `resp_data = 0xDEADBEEF`.
- **Back-to-back streaming:** `resp_rdy = 1`; write addrs 0..7 with data = addr+1 in consecutive cycles, then read 0..7 → `req_rdy` stays 1 throughout; reads return 1..8 in order, one per cycle.
- **Backpressure:** `resp_rdy = 0`; issue 3 reads (addrs 1, 2, 4 preloaded with 0x11, 0x22, 0x44) → only 2 accepted, then `req_rdy = 0`. Raise `resp_rdy` → 0x11, then 0x22. The third request is accepted the cycle after the first `resp_go` and returns 0x44.
- **Reset mid-operation:** with 2 responses queued and addr 2 previously written with 0x5A, assert `reset` asynchronously mid-cycle → `resp_val` drops immediately. After release, read addr 2 → 0.
- **Decoder coverage:** for `p_nwords = 16`, write unique data to all 16 words in random order, then read all → each returns its own data, confirming no aliasing.
